// File: rtl/rw_stage_registered.sv
// Registered register-write stage: captures the MA->RW bundle, selects writeback
// data and destination, and tracks halt and retired-instruction count.
module rw_stage_registered #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_AW   = 4,
    parameter int unsigned CTRL_W   = 22,
    parameter int unsigned RD_LSB   = 22,
    parameter int unsigned RA_INDEX = 15,
    parameter int unsigned PC_STEP  = 4,
    parameter int unsigned LD_BIT   = 1,
    parameter int unsigned CALL_BIT = 8,
    parameter int unsigned WB_BIT   = 6,
    parameter logic [4:0]  HALT_OPC = 5'b11111,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_flush,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_ld_result,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [31:0]       in_ir,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              rw_valid,
    output logic              rw_wb_en,
    output logic [REG_AW-1:0] rw_rd,
    output logic [DATA_W-1:0] rw_data,
    output logic [DATA_W-1:0] rw_pc,
    output logic              halted,
    output logic [CNT_W-1:0]  retired_count
);

    logic              r_valid;
    logic              r_wb_en;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_pc;
    logic              r_halted;
    logic [CNT_W-1:0]  r_count;

    logic              w_capture;
    logic              w_is_ld;
    logic              w_is_call;
    logic              w_is_wb;
    logic              w_is_halt;
    logic [DATA_W-1:0] w_ret_addr;
    logic [DATA_W-1:0] w_wb_data;
    logic [REG_AW-1:0] w_wb_rd;
    logic              w_unused;

    // Decode of the incoming bundle; call outranks load for data selection.
    always_comb begin
        w_capture  = in_valid & ~in_flush & ~r_halted;
        w_is_ld    = in_ctrl[LD_BIT];
        w_is_call  = in_ctrl[CALL_BIT];
        w_is_wb    = in_ctrl[WB_BIT];
        w_is_halt  = (in_ir[31:27] == HALT_OPC);
        w_ret_addr = in_pc + DATA_W'(PC_STEP);
        w_wb_data  = in_alu_result;
        if (w_is_call) begin
            w_wb_data = w_ret_addr;
        end else if (w_is_ld) begin
            w_wb_data = in_ld_result;
        end
        w_wb_rd = w_is_call ? REG_AW'(RA_INDEX) : in_ir[RD_LSB +: REG_AW];
    end

    // Only a subset of the instruction word and control bus is consumed here.
    assign w_unused = ^{in_ir, in_ctrl};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_wb_en  <= 1'b0;
            r_rd     <= '0;
            r_data   <= '0;
            r_pc     <= '0;
            r_halted <= 1'b0;
            r_count  <= '0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_wb_en <= w_is_wb & ~w_is_halt;
            r_rd    <= w_wb_rd;
            r_data  <= w_wb_data;
            r_pc    <= in_pc;
            if (w_is_halt) begin
                r_halted <= 1'b1;
            end
            if (r_count != {CNT_W{1'b1}}) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else begin
            // Bubble: payload registers hold, strobes drop.
            r_valid <= 1'b0;
            r_wb_en <= 1'b0;
        end
    end

    assign rw_valid      = r_valid;
    assign rw_wb_en      = r_wb_en;
    assign rw_rd         = r_rd;
    assign rw_data       = r_data;
    assign rw_pc         = r_pc;
    assign halted        = r_halted;
    assign retired_count = r_count;

endmodule
